// File: rtl/uart_copi_tx_param_if.sv
// Host handshake plus serial/status signals of the parametrised UART transmitter.
// The master side is the word producer. The slave side is the transmitter itself.
interface uart_copi_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] DATA_IN;
    logic                 DATA_VALID;
    logic                 DATA_READY;
    logic                 SER_DATA;
    logic                 BUSY;
    logic                 DONE;
    logic [2:0]           STATE;

    modport master (
        output DATA_IN, DATA_VALID,
        input  DATA_READY, SER_DATA, BUSY, DONE, STATE
    );

    modport slave (
        input  DATA_IN, DATA_VALID,
        output DATA_READY, SER_DATA, BUSY, DONE, STATE
    );
endinterface

// File: rtl/uart_copi_tx_param.sv
// Parametrised UART transmitter sending start, DATA_BITS LSB-first, optional parity and STOP_BITS stop bits.
// Define UART_COPI_TX_PARITY_EN to enable the parity state. Every output is registered.
module uart_copi_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_ODD   = 0
) (
    input logic                 CLK,
    input logic                 RESET,
    uart_copi_tx_param_if.slave bus
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        CLKS_PER_BIT < 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : gIllegalParams
        $error("uart_copi_tx_param: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_COPI_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [BAUD_W-1:0]    baudCnt_q, baudCnt_d;
    logic [BIT_W-1:0]     bitCnt_q, bitCnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 serData_q, serData_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;
`ifdef UART_COPI_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic bitEnd;
    logic accept;

    assign bitEnd = (baudCnt_q == BAUD_LAST);
    assign accept = bus.DATA_VALID && ready_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            serData_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
`ifdef UART_COPI_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            serData_q <= serData_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
`ifdef UART_COPI_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = START;
            START: if (bitEnd) state_d = DATA;
`ifdef UART_COPI_TX_PARITY_EN
            DATA:   if (bitEnd && bitCnt_q == DATA_LAST) state_d = PARITY;
            PARITY: if (bitEnd) state_d = STOP;
`else
            DATA:  if (bitEnd && bitCnt_q == DATA_LAST) state_d = STOP;
`endif
            STOP:  if (bitEnd && bitCnt_q == STOP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The bit counter restarts on every state change, so the data and stop phases both count from 0.
    always_comb begin
        baudCnt_d = (bitEnd || state_q == IDLE) ? '0 : baudCnt_q + 1'b1;

        bitCnt_d = bitCnt_q;
        if (state_d != state_q) begin
            bitCnt_d = '0;
        end else if (bitEnd && (state_q == DATA || state_q == STOP)) begin
            bitCnt_d = bitCnt_q + 1'b1;
        end

        shift_d = shift_q;
        if (accept) begin
            shift_d = bus.DATA_IN;
        end else if (state_q == DATA && bitEnd) begin
            shift_d = shift_q >> 1;
        end

`ifdef UART_COPI_TX_PARITY_EN
        parity_d = parity_q;
        if (accept) begin
            parity_d = (^bus.DATA_IN) ^ (PARITY_ODD != 0);
        end
`endif

        case (state_d)
            START:   serData_d = 1'b0;
            DATA:    serData_d = shift_d[0];
`ifdef UART_COPI_TX_PARITY_EN
            PARITY:  serData_d = parity_q;
`endif
            default: serData_d = 1'b1;
        endcase

        busy_d  = (state_d != IDLE);
        done_d  = (state_q == STOP) && (state_d == IDLE);
        ready_d = (state_d == IDLE);
    end

    assign bus.DATA_READY = ready_q;
    assign bus.SER_DATA   = serData_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.STATE      = state_q;
endmodule

// File: tb/tb_uart_copi_tx_param.sv
// Self-checking bench for uart_copi_tx_param: two instances (8/1/4 even, 7/2/1 odd) checked cycle by cycle
// against a frame model built as a plain list of line bits.
module tb_uart_copi_tx_param;
    localparam int A_BITS = 8, A_STOP = 1, A_CPB = 4, A_ODD = 0;
    localparam int B_BITS = 7, B_STOP = 2, B_CPB = 1, B_ODD = 1;
`ifdef UART_COPI_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef bit bitQ_t[$];

    logic CLK = 1'b0;
    logic RESET;
    int   total = 0;
    int   bad = 0;

    uart_copi_tx_param_if #(.DATA_BITS(A_BITS)) ifA ();
    uart_copi_tx_param_if #(.DATA_BITS(B_BITS)) ifB ();

    uart_copi_tx_param #(
        .DATA_BITS(A_BITS), .STOP_BITS(A_STOP), .CLKS_PER_BIT(A_CPB), .PARITY_ODD(A_ODD)
    ) dutA (
        .CLK(CLK), .RESET(RESET), .bus(ifA)
    );

    uart_copi_tx_param #(
        .DATA_BITS(B_BITS), .STOP_BITS(B_STOP), .CLKS_PER_BIT(B_CPB), .PARITY_ODD(B_ODD)
    ) dutB (
        .CLK(CLK), .RESET(RESET), .bus(ifB)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Snapshot packed as {ser, busy, done, ready, state[2:0]}.
    function automatic logic [6:0] snap(input bit useB);
        if (useB) return {ifB.SER_DATA, ifB.BUSY, ifB.DONE, ifB.DATA_READY, ifB.STATE};
        return {ifA.SER_DATA, ifA.BUSY, ifA.DONE, ifA.DATA_READY, ifA.STATE};
    endfunction

    // Line bits of one frame, one entry per serial bit.
    function automatic bitQ_t frameBits(input logic [15:0] word, input int nBits, input int nStop, input int odd);
        bitQ_t q;
        int ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < nBits; i++) begin
            q.push_back(word[i]);
            ones += int'(word[i]);
        end
        if (P == 1) q.push_back((odd == 1) ? (ones % 2 == 0) : (ones % 2 == 1));
        for (int i = 0; i < nStop; i++) q.push_back(1'b1);
        return q;
    endfunction

    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input bit useB, input logic [15:0] word, input bit holdValid);
        int waited = 0;
        logic [6:0] s;
        s = snap(useB);
        while (s[3] !== 1'b1 && waited < 100) begin
            stepCycle();
            waited++;
            s = snap(useB);
        end
        if (waited >= 100) checkOutput("ready timeout", {31'b0, s[3]}, 32'd1);
        if (useB) begin
            ifB.DATA_IN = word[6:0];
            ifB.DATA_VALID = 1'b1;
        end else begin
            ifA.DATA_IN = word[7:0];
            ifA.DATA_VALID = 1'b1;
        end
        stepCycle();
        if (useB) ifB.DATA_VALID = holdValid;
        else ifA.DATA_VALID = holdValid;
    endtask

    // Called right after the accept edge; returns sampled in the DONE cycle.
    task automatic checkFrame(input bit useB, input logic [15:0] word, input string tag);
        bitQ_t bits;
        logic [6:0] s;
        int nBits = useB ? B_BITS : A_BITS;
        int cpb   = useB ? B_CPB : A_CPB;
        int expState;
        bits = frameBits(word, nBits, useB ? B_STOP : A_STOP, useB ? B_ODD : A_ODD);
        for (int i = 0; i < bits.size(); i++) begin
            expState = (i == 0) ? 1 : (i <= nBits) ? 2 : (P == 1 && i == nBits + 1) ? 3 : 4;
            for (int c = 0; c < cpb; c++) begin
                s = snap(useB);
                checkOutput({tag, " ser"}, {31'b0, s[6]}, {31'b0, bits[i]});
                checkOutput({tag, " busy"}, {31'b0, s[5]}, 32'd1);
                checkOutput({tag, " done"}, {31'b0, s[4]}, 32'd0);
                checkOutput({tag, " ready"}, {31'b0, s[3]}, 32'd0);
                checkOutput({tag, " state"}, {29'b0, s[2:0]}, 32'(expState));
                if (useB) ifB.DATA_IN = 7'($urandom);
                else ifA.DATA_IN = 8'($urandom);
                stepCycle();
            end
        end
        s = snap(useB);
        checkOutput({tag, " end done"}, {31'b0, s[4]}, 32'd1);
        checkOutput({tag, " end ready"}, {31'b0, s[3]}, 32'd1);
        checkOutput({tag, " end busy"}, {31'b0, s[5]}, 32'd0);
        checkOutput({tag, " end ser"}, {31'b0, s[6]}, 32'd1);
        checkOutput({tag, " end state"}, {29'b0, s[2:0]}, 32'd0);
    endtask

    task automatic checkIdle(input string tag, input bit expReady);
        logic [6:0] s;
        for (int u = 0; u < 2; u++) begin
            s = snap(u == 1);
            checkOutput({tag, " ser"}, {31'b0, s[6]}, 32'd1);
            checkOutput({tag, " busy"}, {31'b0, s[5]}, 32'd0);
            checkOutput({tag, " done"}, {31'b0, s[4]}, 32'd0);
            checkOutput({tag, " ready"}, {31'b0, s[3]}, {31'b0, expReady});
            checkOutput({tag, " state"}, {29'b0, s[2:0]}, 32'd0);
        end
    endtask

    initial begin
        logic [6:0] s;
        logic [15:0] w;
        $display("[TB] start, parity bits per frame = %0d", P);
        RESET = 1'b1;
        ifA.DATA_VALID = 1'b0;
        ifA.DATA_IN = '0;
        ifB.DATA_VALID = 1'b0;
        ifB.DATA_IN = '0;
        stepCycle();
        stepCycle();
        checkIdle("reset", 1'b0);
        RESET = 1'b0;
        stepCycle();
        checkIdle("post reset", 1'b1);

        $display("[TB] single frame 0xA5");
        applyStimulus(0, 16'h00A5, 0);
        checkFrame(0, 16'h00A5, "a5");
        stepCycle();
        checkIdle("after a5", 1'b1);

        applyStimulus(0, 16'h0001, 0);
        checkFrame(0, 16'h0001, "x01");

        $display("[TB] back-to-back 0x3C, 0xC3");
        applyStimulus(0, 16'h003C, 1);
        checkFrame(0, 16'h003C, "b2b first");
        applyStimulus(0, 16'h00C3, 0);
        checkFrame(0, 16'h00C3, "b2b second");

        $display("[TB] reset in third data bit");
        applyStimulus(0, 16'h005A, 1);
        repeat (13) stepCycle();
        s = snap(0);
        checkOutput("midrst bit2 ser", {31'b0, s[6]}, 32'd0);
        checkOutput("midrst bit2 state", {29'b0, s[2:0]}, 32'd2);
        RESET = 1'b1;
        ifA.DATA_VALID = 1'b0;
        stepCycle();
        checkIdle("midrst", 1'b0);
        RESET = 1'b0;
        stepCycle();
        checkIdle("midrst release", 1'b1);
        repeat (6) begin
            stepCycle();
            checkIdle("midrst quiet", 1'b1);
        end
        applyStimulus(0, 16'h0055, 0);
        checkFrame(0, 16'h0055, "x55");

        $display("[TB] reset together with valid");
        stepCycle();
        ifA.DATA_IN = 8'h00;
        ifA.DATA_VALID = 1'b1;
        RESET = 1'b1;
        stepCycle();
        checkIdle("rst+valid", 1'b0);
        RESET = 1'b0;
        ifA.DATA_VALID = 1'b0;
        stepCycle();
        checkIdle("rst+valid release", 1'b1);

        $display("[TB] short frame 0x7F on 7/2/1 instance");
        applyStimulus(1, 16'h007F, 0);
        checkFrame(1, 16'h007F, "b7f");
        applyStimulus(1, 16'h0000, 1);
        checkFrame(1, 16'h0000, "b00");
        applyStimulus(1, 16'h002A, 0);
        checkFrame(1, 16'h002A, "b2a");

        $display("[TB] random words");
        for (int n = 0; n < 6; n++) begin
            w = 16'($urandom);
            applyStimulus(0, w & 16'h00FF, (n % 2) == 1);
            checkFrame(0, w & 16'h00FF, "randA");
            w = 16'($urandom);
            applyStimulus(1, w & 16'h007F, (n % 3) == 0);
            checkFrame(1, w & 16'h007F, "randB");
            ifA.DATA_VALID = 1'b0;
            ifB.DATA_VALID = 1'b0;
            stepCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
